// File: rtl/coin_render_pkg.sv
// Shared types and default sprite/animation constants for the coin renderer.
package coin_render_pkg;

  typedef struct packed {
    logic       en;
    logic [9:0] x;
    logic [9:0] y;
  } coin_slot_t;

  localparam int unsigned DEF_N_COINS   = 4;
  localparam int unsigned DEF_SPRITE_W  = 16;
  localparam int unsigned DEF_SPRITE_H  = 16;
  localparam int unsigned DEF_N_FRAMES  = 4;
  localparam int unsigned DEF_FRAME_DIV = 8;
  localparam logic [7:0]  DEF_TRANSP_IDX = 8'd1;

  // Index width that never collapses to zero bits for single-entry sizes.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/coin_hit_detect.sv
// Priority hit test of one scan position against the active coin table.
module coin_hit_detect
  import coin_render_pkg::*;
#(
  parameter int unsigned N_COINS  = DEF_N_COINS,
  parameter int unsigned SPRITE_W = DEF_SPRITE_W,
  parameter int unsigned SPRITE_H = DEF_SPRITE_H,
  parameter int unsigned ID_W     = clog2_min1(N_COINS)
) (
  input  coin_slot_t [N_COINS-1:0] slots,
  input  logic [9:0]               draw_x,
  input  logic [9:0]               draw_y,
  input  logic                     pix_active,
  output logic                     hit,
  output logic [ID_W-1:0]          id,
  output logic [9:0]               col,
  output logic [9:0]               row
);

  logic [N_COINS-1:0][9:0] dx;
  logic [N_COINS-1:0][9:0] dy;
  logic [N_COINS-1:0]      in_box;

  // Unsigned 10-bit differences: a position left of / above the origin
  // wraps to a large value and therefore fails the size compare.
  for (genvar i = 0; i < N_COINS; i++) begin : g_slot
    assign dx[i]     = draw_x - slots[i].x;
    assign dy[i]     = draw_y - slots[i].y;
    assign in_box[i] = slots[i].en && pix_active &&
                       ({1'b0, dx[i]} < 11'(SPRITE_W)) &&
                       ({1'b0, dy[i]} < 11'(SPRITE_H));
  end

  // Scan high to low so the lowest hitting index is the one left standing.
  always_comb begin
    hit = 1'b0;
    id  = '0;
    col = '0;
    row = '0;
    for (int i = N_COINS - 1; i >= 0; i--) begin
      if (in_box[i]) begin
        hit = 1'b1;
        id  = ID_W'(i);
        col = dx[i];
        row = dy[i];
      end
    end
  end

endmodule

// File: rtl/coin_render_ctrl.sv
// Coin sprite render sequencer: double-buffered coin table, spin animation
// counter and a 3-stage hit/ROM/palette pipeline (latency 3, no stalls).
module coin_render_ctrl
  import coin_render_pkg::*;
#(
  parameter int unsigned N_COINS    = DEF_N_COINS,
  parameter int unsigned SPRITE_W   = DEF_SPRITE_W,
  parameter int unsigned SPRITE_H   = DEF_SPRITE_H,
  parameter int unsigned N_FRAMES   = DEF_N_FRAMES,
  parameter int unsigned FRAME_DIV  = DEF_FRAME_DIV,
  parameter logic [7:0]  TRANSP_IDX = DEF_TRANSP_IDX,
  localparam int unsigned ID_W = clog2_min1(N_COINS),
  localparam int unsigned CW   = clog2_min1(SPRITE_W),
  localparam int unsigned RW   = clog2_min1(SPRITE_H),
  localparam int unsigned FW   = clog2_min1(N_FRAMES),
  localparam int unsigned AW   = FW + RW + CW
) (
  input  logic            Clk,
  input  logic            Reset_n,
  input  logic [9:0]      DrawX,
  input  logic [9:0]      DrawY,
  input  logic            pix_active,
  input  logic            frame_sync,
  input  logic            cfg_we,
  input  logic [ID_W-1:0] cfg_idx,
  input  logic [9:0]      cfg_x,
  input  logic [9:0]      cfg_y,
  input  logic            cfg_en,
  output logic [AW-1:0]   rom_addr,
  input  logic [7:0]      rom_data,
  output logic [7:0]      pal_index,
  input  logic [11:0]     pal_rgb,
  output logic            coin_hit,
  output logic [ID_W-1:0] coin_id,
  output logic [3:0]      coin_red,
  output logic [3:0]      coin_green,
  output logic [3:0]      coin_blue
);

  localparam int unsigned DW = clog2_min1(FRAME_DIV);

  coin_slot_t [N_COINS-1:0] shadow_q, shadow_d;
  coin_slot_t [N_COINS-1:0] active_q, active_d;
  logic [DW-1:0]   div_q, div_d;
  logic [FW-1:0]   frame_q, frame_d;

  logic            hit0_q, hit0_d;
  logic [ID_W-1:0] id0_q, id0_d;
  logic [CW-1:0]   col0_q, col0_d;
  logic [RW-1:0]   row0_q, row0_d;
  logic            hit1_q, hit1_d;
  logic [ID_W-1:0] id1_q, id1_d;
  logic [AW-1:0]   rom_addr_q, rom_addr_d;
  logic            coin_hit_q, coin_hit_d;
  logic [ID_W-1:0] coin_id_q, coin_id_d;
  logic [11:0]     rgb_q, rgb_d;

  logic            det_hit;
  logic [ID_W-1:0] det_id;
  logic [9:0]      det_col, det_row;

  coin_hit_detect #(
    .N_COINS (N_COINS),
    .SPRITE_W(SPRITE_W),
    .SPRITE_H(SPRITE_H),
    .ID_W    (ID_W)
  ) u_hit (
    .slots     (active_q),
    .draw_x    (DrawX),
    .draw_y    (DrawY),
    .pix_active(pix_active),
    .hit       (det_hit),
    .id        (det_id),
    .col       (det_col),
    .row       (det_row)
  );

  // Shadow write, then whole-table commit on frame_sync; committing shadow_d
  // lets a write in the frame_sync cycle land in the active table too.
  always_comb begin
    shadow_d = shadow_q;
    if (cfg_we && (32'(cfg_idx) < N_COINS))
      shadow_d[cfg_idx] = '{en: cfg_en, x: cfg_x, y: cfg_y};
    active_d = frame_sync ? shadow_d : active_q;
  end

  // Spin animation: frame_idx steps once every FRAME_DIV frame_sync pulses.
  always_comb begin
    div_d   = div_q;
    frame_d = frame_q;
    if (frame_sync) begin
      if (div_q == DW'(FRAME_DIV - 1)) begin
        div_d   = '0;
        frame_d = frame_q + 1'b1;
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

  // Pipeline: stage 0 captures the hit test, stage 1 launches the ROM address
  // (held on misses), stage 2 merges ROM index and palette colour.
  always_comb begin
    hit0_d     = det_hit;
    id0_d      = det_id;
    col0_d     = det_col[CW-1:0];
    row0_d     = det_row[RW-1:0];
    hit1_d     = hit0_q;
    id1_d      = id0_q;
    rom_addr_d = hit0_q ? {frame_q, row0_q, col0_q} : rom_addr_q;
    coin_hit_d = hit1_q && (rom_data != TRANSP_IDX);
    coin_id_d  = id1_q;
    rgb_d      = coin_hit_d ? pal_rgb : 12'h000;
  end

  // State and pipeline registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      shadow_q   <= '0;
      active_q   <= '0;
      div_q      <= '0;
      frame_q    <= '0;
      hit0_q     <= 1'b0;
      id0_q      <= '0;
      col0_q     <= '0;
      row0_q     <= '0;
      hit1_q     <= 1'b0;
      id1_q      <= '0;
      rom_addr_q <= '0;
      coin_hit_q <= 1'b0;
      coin_id_q  <= '0;
      rgb_q      <= '0;
    end else begin
      shadow_q   <= shadow_d;
      active_q   <= active_d;
      div_q      <= div_d;
      frame_q    <= frame_d;
      hit0_q     <= hit0_d;
      id0_q      <= id0_d;
      col0_q     <= col0_d;
      row0_q     <= row0_d;
      hit1_q     <= hit1_d;
      id1_q      <= id1_d;
      rom_addr_q <= rom_addr_d;
      coin_hit_q <= coin_hit_d;
      coin_id_q  <= coin_id_d;
      rgb_q      <= rgb_d;
    end
  end

  assign rom_addr   = rom_addr_q;
  assign pal_index  = rom_data;
  assign coin_hit   = coin_hit_q;
  assign coin_id    = coin_id_q;
  assign coin_red   = rgb_q[11:8];
  assign coin_green = rgb_q[7:4];
  assign coin_blue  = rgb_q[3:0];

endmodule
